instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the 16-bit processor, sitting between program ROM and the PC/execute stages. It reads the current `pc` and fetches two consecutive 16-bit ROM words (opcode, then operand). It presents them to execute with a valid/ready handshake and pulses `pc_enable` exactly once per retired instruction, so the PC advances or jumps only after execute accepts the instruction.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of ROM words, `opcode`, `operand`, `pc`
- `ADDR_WIDTH`, 17, ROM word address width; must equal `DATA_WIDTH + 1`

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; fetching starts/continues only while high
- `flush`  in  1  one-cycle; abandon current fetch/instruction, return to IDLE
- `pc`  in  DATA_WIDTH  current program counter from PC stage
- `rom_req`  out  1  ROM read request
- `rom_addr`  out  ADDR_WIDTH  ROM word address
- `rom_ack`  in  1  ROM read complete; `rom_rdata` valid this cycle
- `rom_rdata`  in  DATA_WIDTH  ROM read data
- `opcode`  out  DATA_WIDTH  fetched opcode (to PC and execute)
- `operand`  out  DATA_WIDTH  fetched operand / immediate
- `instr_valid`  out  1  opcode/operand valid
- `instr_ready`  in  1  execute accepts instruction (flags for it are final)
- `pc_enable`  out  1  to PC stage: advance/jump this edge
- `busy`  out  1  high in any state except IDLE
- `retired_count`  out  DATA_WIDTH  instructions retired since reset, wraps

## Operation
- States: IDLE, FETCH_OP, FETCH_ARG, ISSUE.
- Reset (async, `reset_n`=0): state IDLE; `opcode`, `operand`, `retired_count` = 0; `rom_req`, `instr_valid`, `pc_enable`, `busy` = 0; `rom_addr` = 0.
- IDLE: if `run` and not `flush` -> FETCH_OP.
- FETCH_OP: `rom_req`=1, `rom_addr`={pc,1'b0}. On `rom_ack` capture `rom_rdata` into `opcode` -> FETCH_ARG.
- FETCH_ARG: `rom_req`=1, `rom_addr`={pc,1'b1}. On `rom_ack` capture into `operand` -> ISSUE.
- ISSUE: `instr_valid`=1; `opcode`/`operand` held stable. On `instr_ready`: `pc_enable`=1 (combinational, = ISSUE & `instr_ready` & ~`flush`). `retired_count` increments at that edge. Next state: FETCH_OP if `run`, else IDLE.
- ROM handshake: `rom_req` is held with a stable `rom_addr` until `rom_ack`. Transfer occurs on `rom_req & rom_ack`. `rom_ack` without `rom_req` is ignored. The ROM keeps no request state; deasserting `rom_req` withdraws the request.
- `pc` is sampled combinationally into `rom_addr`. It is stable during FETCH_* because `pc_enable` is only pulsed in ISSUE.
- `flush` (any state) -> IDLE next edge. It takes priority over a same-cycle `rom_ack` (data discarded) and a same-cycle `instr_ready` (`pc_enable` suppressed, no retire).
- `run` low mid-fetch: the current instruction completes through ISSUE; return to IDLE after retire.
- `retired_count` wraps 0xFFFF -> 0x0000.

## Timing
- Zero-wait ROM (`rom_ack` tied high): `pc` to `instr_valid` takes 2 cycles (FETCH_OP, FETCH_ARG); `instr_valid` is asserted in the 3rd cycle.
- Peak throughput with `instr_ready` tied high: one instruction per 3 cycles.
- Each ROM wait cycle adds one cycle in the corresponding FETCH state.
- `pc_enable` is high for exactly one cycle per retired instruction. The PC stage updates on that edge. The next FETCH_OP uses the new `pc` in the following cycle.
- `opcode`/`operand` update only on their `rom_ack` edge. They retain their values in IDLE and after flush.
- Async reset asserted mid-fetch: all outputs go to reset values immediately. After release: IDLE, then FETCH_OP on the first edge with `run`=1.

## Structure
- Shared processor package holds:
  - `DATA_WIDTH`/`MSB` constants
  - fetch state encoding (IDLE=2'd0, FETCH_OP=2'd1, FETCH_ARG=2'd2, ISSUE=2'd3)
  - the {pc, word-select} ROM address convention
- Single flat module. No sub-module is warranted; the FSM and two capture registers are the whole block.

## Test plan
- Zero-wait ROM, ROM[0]=0x0001, ROM[1]=0x00AA, pc=0, `run`=1, `instr_ready`=1 -> `instr_valid` in cycle 3 with opcode=0x0001, operand=0x00AA; `pc_enable` pulses once; `retired_count`=1.
- ROM `rom_ack` delayed 3 cycles per read, pc=0x0005 -> `rom_addr` held at 0x000A then 0x000B while `rom_req` is high; `instr_valid` appears after 8 cycles.
- Hold `instr_ready`=0 for 5 cycles in ISSUE -> `instr_valid`, `opcode`, `operand` stable; `pc_enable`=0 throughout; single pulse when ready rises.
- `flush` coincident with `rom_ack` in FETCH_ARG -> IDLE next cycle; `operand` unchanged; no `instr_valid`, no `pc_enable`.
- `flush` coincident with `instr_ready` in ISSUE -> `pc_enable`=0; `retired_count` unchanged.
- Preload 0xFFFF retirements (force), retire one more -> `retired_count`=0x0000. Assert `reset_n`=0 mid FETCH_OP -> `rom_req`=0 asynchronously, state IDLE.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the fetch stage:
// word widths, fetch FSM encoding, ROM word addressing.
package instr_fetch_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MSB        = DATA_WIDTH - 1;
  localparam int ADDR_WIDTH = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH_OP  = 2'd1,
    S_FETCH_ARG = 2'd2,
    S_ISSUE     = 2'd3
  } fetch_state_e;

  // Each instruction is two ROM words at {pc, sel}.
  localparam logic WSEL_OP  = 1'b0;
  localparam logic WSEL_ARG = 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] rom_word_addr(
    input logic [MSB:0] pc,
    input logic         sel
  );
    return {pc, sel};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads opcode/operand pair
// from ROM and hands it to execute via valid/ready.
module instr_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  rom_req,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_ack,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  pc_enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] retired_count
);

  import instr_fetch_pkg::*;

  fetch_state_e          r_state;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_retired_count;

  logic w_xfer;
  logic w_retire;

  assign w_xfer   = rom_req & rom_ack;
  assign w_retire = (r_state == S_ISSUE)
                  & instr_ready & ~flush;

  // ROM request and word address decoded from state.
  always_comb begin
    rom_req  = 1'b0;
    rom_addr = '0;
    unique case (r_state)
      S_FETCH_OP: begin
        rom_req  = 1'b1;
        rom_addr = rom_word_addr(pc, WSEL_OP);
      end
      S_FETCH_ARG: begin
        rom_req  = 1'b1;
        rom_addr = rom_word_addr(pc, WSEL_ARG);
      end
      default: begin
        rom_req  = 1'b0;
        rom_addr = '0;
      end
    endcase
  end

  // Fetch FSM and opcode/operand capture; flush wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_operand <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH_OP;
        end
        S_FETCH_OP: begin
          if (w_xfer) begin
            r_opcode <= rom_rdata;
            r_state  <= S_FETCH_ARG;
          end
        end
        S_FETCH_ARG: begin
          if (w_xfer) begin
            r_operand <= rom_rdata;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready)
            r_state <= run ? S_FETCH_OP : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Count retired instructions; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_retired_count <= '0;
    else if (w_retire)
      r_retired_count <= r_retired_count + 1'b1;
  end

  assign opcode        = r_opcode;
  assign operand       = r_operand;
  assign instr_valid   = (r_state == S_ISSUE);
  assign pc_enable     = w_retire;
  assign busy          = (r_state != S_IDLE);
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model with wait states,
// scoreboard of expected opcode/operand pairs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] pc = 16'h0;
  logic        rom_req;
  logic [16:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_rdata;
  logic [15:0] opcode;
  logic [15:0] operand;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_enable;
  logic        busy;
  logic [15:0] retired_count;

  logic [15:0] rom_mem [0:63];
  int          rom_wait = 0;
  int          wcnt = 0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_retired = 16'h0;
  logic [15:0] m_operand = 16'h0;
  logic [31:0] sb [$];

  instr_fetch #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(17)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .flush(flush),
    .pc(pc),
    .rom_req(rom_req),
    .rom_addr(rom_addr),
    .rom_ack(rom_ack),
    .rom_rdata(rom_rdata),
    .opcode(opcode),
    .operand(operand),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_enable(pc_enable),
    .busy(busy),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  assign rom_rdata = rom_mem[rom_addr[5:0]];

  // ROM: acks after rom_wait idle cycles per read
  always @(negedge clk) begin
    if (!rom_req) begin
      wcnt = 0;
      rom_ack = 1'b0;
    end else if (rom_ack && rom_wait > 0) begin
      rom_ack = 1'b0;
      wcnt = 1;
    end else if (wcnt >= rom_wait) begin
      rom_ack = 1'b1;
    end else begin
      wcnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int max,
                            output int cyc,
                            output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < max && !ok) begin
      @(negedge clk);
      cyc++;
      if (instr_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rom_req, instr_valid, pc_enable, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {rom_req, instr_valid, pc_enable, busy});
    end
    n_cmp++;
    if (rom_addr !== 17'h0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h want 0", rom_addr);
    end
    n_cmp++;
    if ({opcode, operand, retired_count} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h want 0",
               opcode, operand, retired_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_run: busy got %b want 0", busy);
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp;
    rom_wait = 0;
    pc = 16'h0;
    instr_ready = 1'b1;
    sb.push_back({16'h0001, 16'h00AA});
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rom_req, instr_valid, rom_addr} !== {2'b10, 17'h0}) begin
      n_bad++;
      $display("FAIL zw_fetch_op: req/valid/addr got %b %b %h want 1 0 0",
               rom_req, instr_valid, rom_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({rom_req, instr_valid, rom_addr} !== {2'b10, 17'h1}) begin
      n_bad++;
      $display("FAIL zw_fetch_arg: req/valid/addr got %b %b %h want 1 0 1",
               rom_req, instr_valid, rom_addr);
    end
    @(negedge clk);
    exp = sb.pop_front();
    m_operand = exp[15:0];
    n_cmp++;
    if ({instr_valid, pc_enable} !== 2'b11) begin
      n_bad++;
      $display("FAIL zw_issue: valid/pc_en got %b %b want 1 1",
               instr_valid, pc_enable);
    end
    n_cmp++;
    if ({opcode, operand} !== exp) begin
      n_bad++;
      $display("FAIL zw_data: got %h %h want %h", opcode, operand, exp);
    end
    run = 1'b0;
    m_retired = m_retired + 16'h1;
    @(negedge clk);
    n_cmp++;
    if ({pc_enable, busy, instr_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL zw_after: pc_en/busy/valid got %b%b%b want 000",
               pc_enable, busy, instr_valid);
    end
    n_cmp++;
    if (retired_count !== m_retired) begin
      n_bad++;
      $display("FAIL zw_count: got %h want %h", retired_count, m_retired);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_wait_hold;
    logic [31:0] exp;
    logic [16:0] want;
    rom_wait = 3;
    pc = 16'h0005;
    rom_mem[10] = 16'h1234;
    rom_mem[11] = 16'h5678;
    instr_ready = 1'b0;
    sb.push_back({16'h1234, 16'h5678});
    @(negedge clk);
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      want = (i <= 4) ? 17'h0000A : 17'h0000B;
      n_cmp++;
      if ({rom_req, instr_valid, rom_addr} !== {2'b10, want}) begin
        n_bad++;
        $display("FAIL ws_cycle%0d: req/valid/addr got %b %b %h want 1 0 %h",
                 i, rom_req, instr_valid, rom_addr, want);
      end
    end
    @(negedge clk);
    exp = sb.pop_front();
    m_operand = exp[15:0];
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({instr_valid, pc_enable, opcode, operand} !== {2'b10, exp}) begin
        n_bad++;
        $display("FAIL hold_%0d: valid/pc_en/op/arg got %b %b %h %h want 1 0 %h",
                 i, instr_valid, pc_enable, opcode, operand, exp);
      end
    end
    instr_ready = 1'b1;
    run = 1'b0;
    #1;
    n_cmp++;
    if (pc_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release: pc_en got %b want 1", pc_enable);
    end
    m_retired = m_retired + 16'h1;
    @(negedge clk);
    n_cmp++;
    if ({pc_enable, busy, retired_count} !== {2'b00, m_retired}) begin
      n_bad++;
      $display("FAIL hold_after: pc_en/busy/count got %b %b %h want 0 0 %h",
               pc_enable, busy, retired_count, m_retired);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_arg;
    rom_wait = 0;
    pc = 16'h0002;
    rom_mem[4] = 16'h4444;
    rom_mem[5] = 16'h5555;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rom_req, rom_addr} !== {1'b1, 17'h5}) begin
      n_bad++;
      $display("FAIL fa_arg: req/addr got %b %h want 1 5", rom_req, rom_addr);
    end
    flush = 1'b1;
    run = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if ({busy, instr_valid, pc_enable} !== 3'b000) begin
      n_bad++;
      $display("FAIL fa_idle: busy/valid/pc_en got %b%b%b want 000",
               busy, instr_valid, pc_enable);
    end
    n_cmp++;
    if ({opcode, operand} !== {16'h4444, m_operand}) begin
      n_bad++;
      $display("FAIL fa_data: got %h %h want 4444 %h",
               opcode, operand, m_operand);
    end
    n_cmp++;
    if (retired_count !== m_retired) begin
      n_bad++;
      $display("FAIL fa_count: got %h want %h", retired_count, m_retired);
    end
  endtask

  task automatic test_flush_issue;
    logic [31:0] exp;
    int cyc;
    bit ok;
    rom_wait = 0;
    pc = 16'h0003;
    rom_mem[6] = 16'h6666;
    rom_mem[7] = 16'h7777;
    instr_ready = 1'b0;
    sb.push_back({16'h6666, 16'h7777});
    @(negedge clk);
    run = 1'b1;
    wait_valid(10, cyc, ok);
    n_cmp++;
    if (!ok || cyc != 3) begin
      n_bad++;
      $display("FAIL fi_latency: valid after %0d cycles (seen %0d) want 3",
               cyc, ok);
    end
    exp = sb.pop_front();
    m_operand = exp[15:0];
    n_cmp++;
    if ({opcode, operand} !== exp) begin
      n_bad++;
      $display("FAIL fi_data: got %h %h want %h", opcode, operand, exp);
    end
    instr_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (pc_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL fi_pc_en: got %b want 0", pc_enable);
    end
    @(negedge clk);
    flush = 1'b0;
    run = 1'b0;
    instr_ready = 1'b0;
    n_cmp++;
    if ({busy, instr_valid, retired_count} !== {2'b00, m_retired}) begin
      n_bad++;
      $display("FAIL fi_after: busy/valid/count got %b %b %h want 0 0 %h",
               busy, instr_valid, retired_count, m_retired);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    int cyc;
    bit ok;
    rom_wait = 0;
    pc = 16'h0008;
    for (int k = 0; k < 3; k++) begin
      rom_mem[16 + 2 * k] = 16'hA000 + 16'(k);
      rom_mem[17 + 2 * k] = 16'hB000 + 16'(k);
      sb.push_back({16'hA000 + 16'(k), 16'hB000 + 16'(k)});
    end
    instr_ready = 1'b1;
    @(negedge clk);
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, cyc, ok);
      n_cmp++;
      if (!ok || cyc != 3 || pc_enable !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d_timing: cycles %0d seen %0d pc_en %b want 3 1 1",
                 k, cyc, ok, pc_enable);
      end
      exp = sb.pop_front();
      m_operand = exp[15:0];
      n_cmp++;
      if ({opcode, operand} !== exp) begin
        n_bad++;
        $display("FAIL b2b_%0d_data: got %h %h want %h",
                 k, opcode, operand, exp);
      end
      m_retired = m_retired + 16'h1;
      pc = pc + 16'h1;
      if (k == 2) run = 1'b0;
    end
    @(negedge clk);
    instr_ready = 1'b0;
    n_cmp++;
    if ({busy, pc_enable, retired_count} !== {2'b00, m_retired}) begin
      n_bad++;
      $display("FAIL b2b_after: busy/pc_en/count got %b %b %h want 0 0 %h",
               busy, pc_enable, retired_count, m_retired);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp;
    int cyc;
    bit ok;
    @(negedge clk);
    force dut.r_retired_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_retired_count;
    m_retired = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if (retired_count !== m_retired) begin
      n_bad++;
      $display("FAIL wrap_preload: got %h want %h", retired_count, m_retired);
    end
    rom_wait = 0;
    pc = 16'h0;
    instr_ready = 1'b1;
    sb.push_back({16'h0001, 16'h00AA});
    run = 1'b1;
    wait_valid(10, cyc, ok);
    exp = sb.pop_front();
    m_operand = exp[15:0];
    n_cmp++;
    if (!ok || {opcode, operand} !== exp) begin
      n_bad++;
      $display("FAIL wrap_issue: seen %0d data %h %h want 1 %h",
               ok, opcode, operand, exp);
    end
    run = 1'b0;
    m_retired = m_retired + 16'h1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_cmp++;
    if (retired_count !== m_retired) begin
      n_bad++;
      $display("FAIL wrap_count: got %h want %h", retired_count, m_retired);
    end
  endtask

  task automatic test_reset_mid;
    rom_wait = 3;
    pc = 16'h0001;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rom_req, rom_addr} !== {1'b1, 17'h2}) begin
      n_bad++;
      $display("FAIL rm_fetch: req/addr got %b %h want 1 2", rom_req, rom_addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rom_req, busy, instr_valid, pc_enable, rom_addr} !== 21'h0) begin
      n_bad++;
      $display("FAIL rm_async: req/busy/valid/pc_en/addr got %b%b%b%b %h want 0",
               rom_req, busy, instr_valid, pc_enable, rom_addr);
    end
    n_cmp++;
    if ({opcode, operand, retired_count} !== 48'h0) begin
      n_bad++;
      $display("FAIL rm_data: got %h %h %h want 0",
               opcode, operand, retired_count);
    end
    m_retired = 16'h0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_release: busy got %b want 0", busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, rom_req, rom_addr} !== {2'b11, 17'h2}) begin
      n_bad++;
      $display("FAIL rm_restart: busy/req/addr got %b %b %h want 1 1 2",
               busy, rom_req, rom_addr);
    end
    flush = 1'b1;
    run = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if ({busy, retired_count} !== {1'b0, m_retired}) begin
      n_bad++;
      $display("FAIL rm_end: busy/count got %b %h want 0 %h",
               busy, retired_count, m_retired);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      rom_mem[i] = 16'hC000 + 16'(i);
    rom_mem[0] = 16'h0001;
    rom_mem[1] = 16'h00AA;
    test_reset();
    test_zero_wait();
    test_wait_hold();
    test_flush_arg();
    test_flush_issue();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
